// File: rtl/sed_scan_ctrl.sv
// -----------------------------------------------------------------------------
// sed_scan_ctrl -- soft-error-detect scan controller
//
// Walks NUM_REGIONS configuration regions of WORDS_PER_REGION 32-bit words
// through a synchronous read port. A CRC-16-CCITT (poly 0x1021, init 0xFFFF,
// 32 bits per update, MSB first, no final XOR) is accumulated over every word
// of a region except the last. The low 16 bits of the last word hold the
// golden CRC. A mismatch, or a forced error, sets that region's sticky flag
// and bumps a saturating error counter.
//
// Optional build macro:
//   SED_HALT_ON_ERR_EN - a region check that raises a flag ends the scan at
//                        once (DONE pulse). No automatic restart follows
//                        that scan.
//
// Ports:
//   CLK        in   system clock
//   RSTN       in   asynchronous active-low reset
//   SEDENABLE  in   block enable; low aborts a scan in progress
//   SEDSTART   in   level start request, sampled only in IDLE
//   SEDFRCERR  in   per-region forced mismatch, sampled in that region's check
//   SEDCLRERR  in   clear flags and counter (takes effect next cycle)
//   SEDADDR    out  word address (region*WORDS_PER_REGION + word)
//   SEDRDATA   in   read data, valid one CLK after SEDADDR
//   SEDERRREG  out  sticky per-region error flags
//   SEDERR     out  OR of SEDERRREG
//   SEDERRCNT  out  saturating mismatch count
//   SEDINPROG  out  scan active
//   SEDDONE    out  one-cycle pulse at scan end
//   SEDCLKOUT  out  scan-tick-rate clock, low while disabled
// -----------------------------------------------------------------------------
module sed_scan_ctrl #(
    parameter int CLK_DIV          = 1,
    parameter int NUM_REGIONS      = 4,
    parameter int WORDS_PER_REGION = 64,
    parameter int ERRCNT_W         = 8,
    parameter int CHECKALWAYS      = 0,
    localparam int AW              = $clog2(NUM_REGIONS * WORDS_PER_REGION)
) (
    input  logic                   CLK,
    input  logic                   RSTN,
    input  logic                   SEDENABLE,
    input  logic                   SEDSTART,
    input  logic [NUM_REGIONS-1:0] SEDFRCERR,
    input  logic                   SEDCLRERR,
    output logic [AW-1:0]          SEDADDR,
    input  logic [31:0]            SEDRDATA,
    output logic [NUM_REGIONS-1:0] SEDERRREG,
    output logic                   SEDERR,
    output logic [ERRCNT_W-1:0]    SEDERRCNT,
    output logic                   SEDINPROG,
    output logic                   SEDDONE,
    output logic                   SEDCLKOUT
);

    localparam int TW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int WW = $clog2(WORDS_PER_REGION);
    localparam int RW = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;

    localparam logic [TW-1:0] TICK_LAST   = TW'(CLK_DIV - 1);
    localparam logic [WW-1:0] WORD_LAST   = WW'(WORDS_PER_REGION - 1);
    localparam logic [RW-1:0] REGION_LAST = RW'(NUM_REGIONS - 1);
    localparam logic [15:0]   CRC_INIT    = 16'hFFFF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_CAPTURE,
        S_CHECK,
        S_DONE
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;

    logic [TW-1:0]          r_tick;
    logic [WW-1:0]          r_word;
    logic [RW-1:0]          r_region;
    logic [15:0]            r_crc;
    logic                   r_mismatch;
    logic                   r_halted;
    logic [AW-1:0]          r_addr;
    logic [NUM_REGIONS-1:0] r_errreg;
    logic [ERRCNT_W-1:0]    r_errcnt;
    logic [TW-1:0]          r_div;
    logic                   r_clkout;

    logic                   w_tick_last;
    logic                   w_word_last;
    logic                   w_region_last;
    logic [NUM_REGIONS-1:0] w_region_sel;
    logic                   w_flag_hit;
    logic                   w_halt;
    logic                   w_enter_issue;

    // One 32-bit CRC-16-CCITT step, data consumed MSB first.
    function automatic logic [15:0] crc16_upd(input logic [15:0] crc_in,
                                              input logic [31:0] data);
        logic [15:0] c;
        logic        fb;
        c = crc_in;
        for (int i = 31; i >= 0; i--) begin
            fb = c[15] ^ data[i];
            c  = {c[14:0], 1'b0};
            if (fb) c = c ^ 16'h1021;
        end
        return c;
    endfunction

    assign w_tick_last   = (r_tick == TICK_LAST);
    assign w_word_last   = (r_word == WORD_LAST);
    assign w_region_last = (r_region == REGION_LAST);
    assign w_region_sel  = NUM_REGIONS'(1) << r_region;

    // A region check raises its flag on a golden mismatch or a forced error.
    assign w_flag_hit = (r_state == S_CHECK) &&
                        (r_mismatch || (|(SEDFRCERR & w_region_sel)));

`ifdef SED_HALT_ON_ERR_EN
    assign w_halt = w_flag_hit;
`else
    assign w_halt = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // FSM state register
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_state <= S_IDLE;
        end else begin
            // NOTE: state is updated with non-blocking assignments so every
            // flop in the design samples the same pre-edge values.
            r_state <= w_state_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // FSM next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: default first so every path assigns w_state_nxt and no latch
        // is inferred.
        w_state_nxt = r_state;
        if ((r_state != S_IDLE) && !SEDENABLE) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (SEDENABLE && SEDSTART) w_state_nxt = S_ISSUE;
                end
                S_ISSUE: begin
                    if (w_tick_last) w_state_nxt = S_CAPTURE;
                end
                S_CAPTURE: begin
                    w_state_nxt = w_word_last ? S_CHECK : S_ISSUE;
                end
                S_CHECK: begin
                    w_state_nxt = (w_region_last || w_halt) ? S_DONE : S_ISSUE;
                end
                S_DONE: begin
                    w_state_nxt = ((CHECKALWAYS != 0) && SEDENABLE && !r_halted)
                                  ? S_ISSUE : S_IDLE;
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    assign w_enter_issue = (w_state_nxt == S_ISSUE) && (r_state != S_ISSUE);

    // -------------------------------------------------------------------------
    // Scan datapath: address, word/region/tick counters, CRC
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_tick     <= '0;
            r_word     <= '0;
            r_region   <= '0;
            r_crc      <= CRC_INIT;
            r_mismatch <= 1'b0;
            r_halted   <= 1'b0;
            r_addr     <= '0;
        end else begin
            // Regions are laid out back to back, so every new ISSUE after the
            // first of a scan is simply the next linear address.
            if (w_enter_issue) begin
                r_addr <= ((r_state == S_IDLE) || (r_state == S_DONE))
                          ? '0 : r_addr + 1'b1;
            end

            if (w_enter_issue) begin
                r_tick <= '0;
            end else if (r_state == S_ISSUE) begin
                r_tick <= r_tick + 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_state_nxt == S_ISSUE) begin
                        r_word   <= '0;
                        r_region <= '0;
                        r_crc    <= CRC_INIT;
                        r_halted <= 1'b0;
                    end
                end
                S_CAPTURE: begin
                    if (!w_word_last) begin
                        r_crc  <= crc16_upd(r_crc, SEDRDATA);
                        r_word <= r_word + 1'b1;
                    end else begin
                        r_mismatch <= (SEDRDATA[15:0] != r_crc);
                    end
                end
                S_CHECK: begin
                    r_crc  <= CRC_INIT;
                    r_word <= '0;
                    if (!w_region_last) r_region <= r_region + 1'b1;
                    if (w_halt) r_halted <= 1'b1;
                end
                S_DONE: begin
                    r_word   <= '0;
                    r_region <= '0;
                end
                default: ;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Sticky flags and saturating counter. A clear coinciding with a flag
    // set leaves only the new event recorded.
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_errreg <= '0;
            r_errcnt <= '0;
        end else if (SEDCLRERR) begin
            r_errreg <= w_flag_hit ? w_region_sel : '0;
            r_errcnt <= w_flag_hit ? ERRCNT_W'(1) : '0;
        end else if (w_flag_hit) begin
            r_errreg <= r_errreg | w_region_sel;
            if (r_errcnt != {ERRCNT_W{1'b1}}) r_errcnt <= r_errcnt + 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Scan-tick clock: free-running divider, toggles every CLK_DIV cycles
    // while enabled, held low otherwise.
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_div    <= '0;
            r_clkout <= 1'b0;
        end else if (!SEDENABLE) begin
            r_div    <= '0;
            r_clkout <= 1'b0;
        end else if (r_div == TICK_LAST) begin
            r_div    <= '0;
            r_clkout <= ~r_clkout;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign SEDADDR   = r_addr;
    assign SEDERRREG = r_errreg;
    assign SEDERR    = |r_errreg;
    assign SEDERRCNT = r_errcnt;
    assign SEDINPROG = (r_state == S_ISSUE) || (r_state == S_CAPTURE) ||
                       (r_state == S_CHECK);
    assign SEDDONE   = (r_state == S_DONE);
    assign SEDCLKOUT = r_clkout;

endmodule

// File: tb/tb_sed_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sed_scan_ctrl -- self-checking bench for sed_scan_ctrl
//
// dut_a: 2 regions x 4 words, CLK_DIV=1, one-shot, 8-bit counter.
// dut_b: same geometry, CHECKALWAYS=1, 2-bit counter (saturation).
// Each DUT reads a synchronous memory model whose golden words are computed
// here with an independent CRC-16-CCITT reference.
// -----------------------------------------------------------------------------
module tb_sed_scan_ctrl;

    logic CLK;
    logic RSTN;

    // dut_a
    logic        en_a, start_a, clr_a;
    logic [1:0]  frc_a;
    logic [2:0]  addr_a;
    logic [31:0] rdata_a;
    logic [1:0]  errreg_a;
    logic        err_a, inprog_a, done_a, clkout_a;
    logic [7:0]  errcnt_a;

    // dut_b
    logic        en_b, start_b;
    logic [2:0]  addr_b;
    logic [31:0] rdata_b;
    logic [1:0]  errreg_b;
    logic        err_b, inprog_b, done_b, clkout_b;
    logic [1:0]  errcnt_b;

    logic [31:0] mem_a [0:7];
    logic [31:0] mem_b [0:7];

    int total = 0;
    int bad   = 0;
    int max_addr_a;

    typedef struct {
        logic [1:0] reg_v;
        int         cnt;
        int         done_cyc;
    } exp_t;

    exp_t sb_a[$];
    exp_t sb_b[$];

    typedef struct {
        logic [1:0] corrupt;   // regions whose golden word gets XOR 0x0001
        logic [1:0] frc;       // SEDFRCERR held during the scan
        logic       clr_first; // SEDCLRERR pulse in IDLE before the scan
        int         clr_cyc;   // scan cycle carrying SEDCLRERR (0 = none)
        logic [1:0] exp_reg;
        int         exp_cnt;
    } vec_t;

    vec_t vecs [9];

    sed_scan_ctrl #(
        .CLK_DIV(1), .NUM_REGIONS(2), .WORDS_PER_REGION(4),
        .ERRCNT_W(8), .CHECKALWAYS(0)
    ) dut_a (
        .CLK(CLK), .RSTN(RSTN), .SEDENABLE(en_a), .SEDSTART(start_a),
        .SEDFRCERR(frc_a), .SEDCLRERR(clr_a), .SEDADDR(addr_a),
        .SEDRDATA(rdata_a), .SEDERRREG(errreg_a), .SEDERR(err_a),
        .SEDERRCNT(errcnt_a), .SEDINPROG(inprog_a), .SEDDONE(done_a),
        .SEDCLKOUT(clkout_a)
    );

    sed_scan_ctrl #(
        .CLK_DIV(1), .NUM_REGIONS(2), .WORDS_PER_REGION(4),
        .ERRCNT_W(2), .CHECKALWAYS(1)
    ) dut_b (
        .CLK(CLK), .RSTN(RSTN), .SEDENABLE(en_b), .SEDSTART(start_b),
        .SEDFRCERR(2'b00), .SEDCLRERR(1'b0), .SEDADDR(addr_b),
        .SEDRDATA(rdata_b), .SEDERRREG(errreg_b), .SEDERR(err_b),
        .SEDERRCNT(errcnt_b), .SEDINPROG(inprog_b), .SEDDONE(done_b),
        .SEDCLKOUT(clkout_b)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    always @(posedge CLK) begin
        rdata_a <= mem_a[addr_a];
        rdata_b <= mem_b[addr_b];
    end

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference CRC over a 96-bit stream (three words, first word MSB first).
    function automatic logic [15:0] ref_crc(input logic [95:0] stream);
        logic [15:0] c;
        logic        fb;
        c = 16'hFFFF;
        for (int i = 95; i >= 0; i--) begin
            fb = c[15] ^ stream[i];
            c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
        end
        return c;
    endfunction

    task automatic fill_mem_a(input logic [1:0] corrupt);
        logic [15:0] g;
        for (int r = 0; r < 2; r++) begin
            for (int w = 0; w < 3; w++) mem_a[r*4+w] = $urandom;
            g = ref_crc({mem_a[r*4], mem_a[r*4+1], mem_a[r*4+2]});
            mem_a[r*4+3] = {16'($urandom), g ^ {15'b0, corrupt[r]}};
        end
    endtask

    task automatic fill_mem_b(input logic [1:0] corrupt);
        logic [15:0] g;
        for (int r = 0; r < 2; r++) begin
            for (int w = 0; w < 3; w++) mem_b[r*4+w] = $urandom;
            g = ref_crc({mem_b[r*4], mem_b[r*4+1], mem_b[r*4+2]});
            mem_b[r*4+3] = {16'($urandom), g ^ {15'b0, corrupt[r]}};
        end
    endtask

    // One scan on dut_a. Cycle 1 is the cycle after the accepting edge.
    task automatic run_scan(input logic [1:0] frc, input int clr_cyc,
                            input logic [1:0] exp_reg, input int exp_cnt,
                            input int exp_done);
        exp_t e;
        int   cyc, done_cyc, inprog_n, toggles;
        logic last_clk;
        sb_a.push_back('{exp_reg, exp_cnt, exp_done});
        frc_a   = frc;
        start_a = 1'b1;
        @(posedge CLK); #1;
        start_a    = 1'b0;
        cyc        = 1;
        done_cyc   = 0;
        inprog_n   = 0;
        toggles    = 0;
        max_addr_a = 0;
        last_clk   = clkout_a;
        while (cyc <= 40) begin
            clr_a = (cyc == clr_cyc);
            if (clkout_a !== last_clk) toggles++;
            last_clk = clkout_a;
            if (int'(addr_a) > max_addr_a) max_addr_a = int'(addr_a);
            if (inprog_a) inprog_n++;
            if (done_a) begin
                done_cyc = cyc;
                break;
            end
            @(posedge CLK); #1;
            cyc++;
        end
        clr_a = 1'b0;
        e = sb_a.pop_front();
        check("done_cycle", done_cyc, e.done_cyc);
        check("errreg", errreg_a, e.reg_v);
        check("errcnt", errcnt_a, e.cnt);
        check("err_or", err_a, (e.reg_v != 2'b00));
        check("inprog_cycles", inprog_n, e.done_cyc - 1);
        check("clkout_toggles", toggles, e.done_cyc - 1);
        @(posedge CLK); #1;
        check("done_pulse_end", done_a, 0);
        check("inprog_after", inprog_a, 0);
        frc_a = 2'b00;
    endtask

    initial begin
        int seen, cyc, dones;
        int done_at[5];
        exp_t e;

        RSTN = 1'b0; en_a = 1'b0; start_a = 1'b0; clr_a = 1'b0; frc_a = 2'b00;
        en_b = 1'b0; start_b = 1'b0;
        fill_mem_a(2'b00);
        fill_mem_b(2'b01);

        //               corrupt frc  clrF clrC  reg   cnt
        vecs[0] = '{2'b00, 2'b00, 1'b0, 0, 2'b00, 0};
        vecs[1] = '{2'b10, 2'b00, 1'b0, 0, 2'b10, 1};
        vecs[2] = '{2'b10, 2'b00, 1'b0, 0, 2'b10, 2};
        vecs[3] = '{2'b00, 2'b00, 1'b1, 0, 2'b00, 0};
        vecs[4] = '{2'b00, 2'b01, 1'b0, 0, 2'b01, 1};
        vecs[5] = '{2'b11, 2'b00, 1'b0, 0, 2'b11, 3};
        vecs[6] = '{2'b01, 2'b10, 1'b1, 0, 2'b11, 2};
        vecs[7] = '{2'b00, 2'b01, 1'b0, 9, 2'b01, 1};  // clear at region-0 CHECK
        vecs[8] = '{2'b00, 2'b00, 1'b0, 0, 2'b01, 1};

        repeat (3) @(posedge CLK);
        #1;
        check("rst_addr", addr_a, 0);
        check("rst_errreg", errreg_a, 0);
        check("rst_errcnt", errcnt_a, 0);
        check("rst_inprog", inprog_a, 0);
        check("rst_done", done_a, 0);
        check("rst_clkout", clkout_a, 0);
        #4 RSTN = 1'b1;
        @(posedge CLK); #1;
        en_a = 1'b1;
        @(posedge CLK); #1;

`ifndef SED_HALT_ON_ERR_EN
        for (int i = 0; i < 9; i++) begin
            fill_mem_a(vecs[i].corrupt);
            if (vecs[i].clr_first) begin
                clr_a = 1'b1;
                @(posedge CLK); #1;
                clr_a = 1'b0;
            end
            run_scan(vecs[i].frc, vecs[i].clr_cyc, vecs[i].exp_reg,
                     vecs[i].exp_cnt, 19);
            check("max_addr", max_addr_a, 7);
        end
`else
        // Region 0 corrupt: the scan halts after region 0's check.
        fill_mem_a(2'b01);
        run_scan(2'b00, 0, 2'b01, 1, 10);
        check("halt_max_addr", max_addr_a, 3);
`endif

        // Abort: SEDENABLE low during cycle 7. Flags/counter (01, 1) stay.
        fill_mem_a(2'b00);
        start_a = 1'b1;
        @(posedge CLK); #1;
        start_a = 1'b0;
        repeat (6) begin @(posedge CLK); #1; end
        en_a = 1'b0;
        @(posedge CLK); #1;
        check("abort_inprog", inprog_a, 0);
        check("abort_clkout", clkout_a, 0);
        seen = 0;
        repeat (30) begin
            if (done_a) seen++;
            @(posedge CLK); #1;
        end
        check("abort_no_done", seen, 0);
        check("abort_errreg", errreg_a, 2'b01);
        check("abort_errcnt", errcnt_a, 1);
        en_a = 1'b1;
        @(posedge CLK); #1;

`ifndef SED_HALT_ON_ERR_EN
        // Continuous mode, region 0 corrupt, 2-bit counter saturates.
        for (int k = 0; k < 5; k++) sb_b.push_back('{2'b01, (k < 3) ? k + 1 : 3, 19 * (k + 1)});
        en_b    = 1'b1;
        start_b = 1'b1;
        @(posedge CLK); #1;
        start_b = 1'b0;
        cyc   = 1;
        dones = 0;
        while (cyc <= 200 && dones < 5) begin
            if (done_b) begin
                done_at[dones] = cyc;
                e = sb_b.pop_front();
                check("b_done_cycle", cyc, e.done_cyc);
                check("b_errcnt", errcnt_b, e.cnt);
                check("b_errreg", errreg_b, e.reg_v);
                dones++;
            end
            if (dones < 5) begin
                @(posedge CLK); #1;
                cyc++;
            end
        end
        en_b = 1'b0;
        check("b_done_count", dones, 5);
        for (int k = 1; k < dones; k++) check("b_done_period", done_at[k] - done_at[k-1], 19);
`endif

        // Reset mid-scan: outputs clear without waiting for a clock edge.
        start_a = 1'b1;
        @(posedge CLK); #1;
        start_a = 1'b0;
        repeat (4) begin @(posedge CLK); #1; end
        check("pre_rst_addr", addr_a, 2);
        RSTN = 1'b0;
        #1;
        check("mid_rst_addr", addr_a, 0);
        check("mid_rst_errreg", errreg_a, 0);
        check("mid_rst_err", err_a, 0);
        check("mid_rst_errcnt", errcnt_a, 0);
        check("mid_rst_inprog", inprog_a, 0);
        check("mid_rst_done", done_a, 0);
        check("mid_rst_clkout", clkout_a, 0);
        #3 RSTN = 1'b1;
        @(posedge CLK); #1;
        check("post_rst_idle", inprog_a, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sed_scan_ctrl.md
Name: sed_scan_ctrl

Overview:
- Parametrised soft-error-detect scan controller; successor to the single-region SED primitive model.
- Walks NUM_REGIONS configuration regions of WORDS_PER_REGION 32-bit words through a read port.
- Computes a CRC-16 per region and compares it against the golden value stored in each region's last word.
- Reports per-region sticky error flags, a saturating error count, a start/in-progress/done handshake and a divided scan clock; one-shot or continuous mode.

Parameters:
- CLK_DIV, 1: CLK cycles per scan tick (>=1).
- NUM_REGIONS, 4: number of regions (>=1).
- WORDS_PER_REGION, 64: words per region including the golden word (>=2).
- ERRCNT_W, 8: error counter width.
- CHECKALWAYS, 0: 1 = restart scan automatically after DONE.

Ports:
- CLK  in  1  system clock.
- RSTN  in  1  asynchronous active-low reset.
- SEDENABLE  in  1  block enable; low aborts the scan.
- SEDSTART  in  1  level request, sampled in IDLE.
- SEDFRCERR  in  NUM_REGIONS  force mismatch on region r.
- SEDCLRERR  in  1  clear flags and counter.
- SEDADDR  out  AW=clog2(NUM_REGIONS*WORDS_PER_REGION)  word address.
- SEDRDATA  in  32  read data, valid one CLK after SEDADDR.
- SEDERRREG  out  NUM_REGIONS  sticky per-region error flags.
- SEDERR  out  1  OR of SEDERRREG.
- SEDERRCNT  out  ERRCNT_W  saturating mismatch count.
- SEDINPROG  out  1  scan active.
- SEDDONE  out  1  one-cycle pulse at scan end.
- SEDCLKOUT  out  1  tick-rate clock, low when disabled.

Behaviour:
- Reset: the asynchronous, active-low RSTN sets all outputs to 0, the FSM to IDLE and the CRC to 0xFFFF.
- CRC: CRC-16-CCITT (poly 0x1021, init 0xFFFF), 32 bits per update, MSB first, no final XOR.
- FSM states:
  - IDLE: when SEDENABLE=1 and SEDSTART=1, go to ISSUE with region=0, word=0, CRC=0xFFFF; SEDINPROG=1 from the next cycle.
  - ISSUE: drive SEDADDR = region*WORDS_PER_REGION + word and hold it; the tick counter resets on entry; leave after CLK_DIV cycles for CAPTURE.
  - CAPTURE (1 cycle): sample SEDRDATA.
    - word < WORDS_PER_REGION-1: update the CRC, increment word, go to ISSUE.
    - Otherwise: latch mismatch = (SEDRDATA[15:0] != CRC) and go to CHECK.
  - CHECK (1 cycle): if mismatch or SEDFRCERR[region], set SEDERRREG[region] and increment SEDERRCNT (saturating at all-ones). Then reset the CRC and set word=0.
    - region < NUM_REGIONS-1: increment region, go to ISSUE.
    - Otherwise: go to DONE.
  - DONE (1 cycle): SEDDONE=1, SEDINPROG=0.
    - CHECKALWAYS=1 and SEDENABLE=1: go to ISSUE at region 0.
    - Otherwise: go to IDLE.
- Timing:
  - Scan length L = NUM_REGIONS*(WORDS_PER_REGION*(CLK_DIV+1)+1) cycles.
  - SEDDONE is high in cycle L+1 after the accepting edge.
- SEDENABLE=0 in any non-IDLE state: go to IDLE next cycle with no SEDDONE; flags and counter are retained; SEDINPROG drops.
- SEDCLRERR: clears SEDERRREG and SEDERRCNT next cycle.
  - If it coincides with a CHECK set for region r: result is SEDERRREG = only bit r, SEDERRCNT = 1.
- SEDSTART asserted while not IDLE: ignored.
- SEDFRCERR is sampled only in CHECK for the current region.
- SEDCLKOUT toggles on each tick boundary while SEDENABLE=1; otherwise 0.
- SEDADDR holds its last value outside ISSUE.

Optional Feature:
- Macro SED_HALT_ON_ERR_EN.
- Defined: a CHECK that sets any flag goes directly to DONE (SEDDONE pulse), skipping the remaining regions; CHECKALWAYS restart is suppressed after a halted scan.
- Undefined: all regions are always scanned.

Test Plan:
- Config NUM_REGIONS=2, WORDS_PER_REGION=4, CLK_DIV=1, all golden words correct; pulse SEDSTART -> SEDDONE exactly at cycle 19, SEDERR=0, SEDERRCNT=0, SEDINPROG high cycles 1-18.
- Same config, region 1 golden corrupted (XOR 0x0001) -> SEDERRREG=2'b10, SEDERRCNT=1 after DONE; a second scan -> SEDERRCNT=2.
- SEDFRCERR=2'b01 held with clean memory -> SEDERRREG=2'b01; SEDCLRERR coinciding with region-0 CHECK on the next scan -> SEDERRREG=2'b01, SEDERRCNT=1.
- CHECKALWAYS=1, ERRCNT_W=2, region 0 corrupt; run 5 scans -> SEDERRCNT saturates at 3; SEDDONE every 19 cycles.
- Drop SEDENABLE at cycle 7 -> IDLE at cycle 8, no SEDDONE, SEDCLKOUT=0; RSTN low mid-scan -> all outputs 0 immediately.
- With SED_HALT_ON_ERR_EN and region 0 corrupt -> SEDDONE at cycle 10, region 1 addresses never issued.
